// File: rtl/dmem_lsu_pkg.sv
// Shared encodings, FSM state type and default constants for the data-memory LSU.
package dmem_lsu_pkg;

  localparam int DATA_W                 = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_align.sv
// lsu_align: byte-lane enables, store-data replication and load extraction/extension.
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] v, input logic s);
    logic signed [DATA_W-1:0] sx;
    sx = $signed(v);
    if (s) return sx;
    return {{(DATA_W-8){1'b0}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] v, input logic s);
    logic signed [DATA_W-1:0] sx;
    sx = $signed(v);
    if (s) return sx;
    return {{(DATA_W-16){1'b0}}, v};
  endfunction

  logic [1:0]        lane;
  logic [DATA_W-1:0] rshift;

  // Size code 11 falls into the word branch; misaligned halves/words collapse onto legal lanes.
  always_comb begin
    lane      = 2'b00;
    be        = 4'b1111;
    wdata_rep = wdata;
    case (size)
      SIZE_BYTE: begin
        lane      = addr_lo;
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        lane      = {addr_lo[1], 1'b0};
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        lane      = 2'b00;
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  always_comb begin
    rshift = rdata >> {lane, 3'b000};
    case (size)
      SIZE_BYTE: rdata_ext = ext_byte(rshift[7:0], sign_ext);
      SIZE_HALF: rdata_ext = ext_half(rshift[15:0], sign_ext);
      default:   rdata_ext = rshift;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store unit in front of a word-wide memory.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned accesses return an error without touching memory.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e state_q, state_d;

  logic              we_p0;
  logic [1:0]        size_p0;
  logic              sign_p0;
  logic [31:0]       addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] rdata_p1;
  logic              err_p1;
  logic [CNT_W-1:0]  tmo_cnt;

  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_rep_c;
  logic [DATA_W-1:0] rdata_ext_c;
  logic              misalign;
  logic              accept;
  logic              timeout;

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    case (req_size)
      SIZE_BYTE: misalign = 1'b0;
      SIZE_HALF: misalign = req_addr[0];
      default:   misalign = |req_addr[1:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign accept  = (state_q == ST_IDLE) && req_valid;
  assign timeout = (state_q == ST_WAIT) && !mem_rvalid && (tmo_cnt == CNT_LAST);

  lsu_align u_align (
    .size      (size_p0),
    .addr_lo   (addr_p0[1:0]),
    .sign_ext  (sign_p0),
    .wdata     (wdata_p0),
    .rdata     (mem_rdata),
    .be        (be_c),
    .wdata_rep (wdata_rep_c),
    .rdata_ext (rdata_ext_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = misalign ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_gnt)   state_d = we_p0 ? ST_RESP : ST_WAIT;
      ST_WAIT: if (mem_rvalid || timeout) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p0: request capture at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      size_p0  <= req_size;
      sign_p0  <= req_signed;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  // Stage p1: response data, error flag and WAIT timeout counter
  always_ff @(posedge clk) begin
    if (accept)                                     rdata_p1 <= '0;
    else if ((state_q == ST_WAIT) && mem_rvalid)    rdata_p1 <= rdata_ext_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_p1  <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (accept)       err_p1 <= misalign;
      else if (timeout) err_p1 <= 1'b1;
      if ((state_q == ST_REQ) && mem_gnt)
        tmo_cnt <= '0;
      else if ((state_q == ST_WAIT) && !mem_rvalid && !timeout)
        tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // Data-bearing outputs are gated by state so they read zero outside their phase and in reset.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = (state_q == ST_RESP) && err_p1;
  assign resp_rdata = (state_q == ST_RESP) ? rdata_p1 : '0;
  assign mem_req    = (state_q == ST_REQ);
  assign mem_we     = (state_q == ST_REQ) && we_p0;
  assign mem_be     = (state_q == ST_REQ) ? be_c : 4'b0000;
  assign mem_addr   = (state_q == ST_REQ) ? {addr_p0[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = (state_q == ST_REQ) ? wdata_rep_c : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu (TIMEOUT_CYCLES = 8).
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  dmem_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_rd);
    req_valid = 1'b1; req_we = 1'b0; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = 32'h0;
    tick();
    req_valid = 1'b0;
    check({tag, ":mem_req"},   {31'b0, mem_req}, 32'd1);
    check({tag, ":mem_we"},    {31'b0, mem_we}, 32'd0);
    check({tag, ":mem_addr"},  mem_addr, {addr[31:2], 2'b00});
    check({tag, ":mem_be"},    {28'b0, mem_be}, {28'b0, exp_be});
    check({tag, ":req_ready"}, {31'b0, req_ready}, 32'd0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check({tag, ":wait_req"},  {31'b0, mem_req}, 32'd0);
    check({tag, ":wait_resp"}, {31'b0, resp_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check({tag, ":resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, ":resp_rdata"}, resp_rdata, exp_rd);
    check({tag, ":resp_err"},   {31'b0, resp_err}, 32'd0);
    tick();
    check({tag, ":resp_pulse"}, {31'b0, resp_valid}, 32'd0);
    check({tag, ":ready_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wd, input int gnt_delay,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    req_valid = 1'b1; req_we = 1'b1; req_size = size; req_signed = 1'b0;
    req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i <= gnt_delay; i++) begin
      check({tag, ":mem_req"},   {31'b0, mem_req}, 32'd1);
      check({tag, ":mem_we"},    {31'b0, mem_we}, 32'd1);
      check({tag, ":mem_addr"},  mem_addr, {addr[31:2], 2'b00});
      check({tag, ":mem_be"},    {28'b0, mem_be}, {28'b0, exp_be});
      check({tag, ":mem_wdata"}, mem_wdata, exp_wd);
      if (i == gnt_delay) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    check({tag, ":resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, ":resp_err"},   {31'b0, resp_err}, 32'd0);
    check({tag, ":resp_rdata"}, resp_rdata, 32'h0);
    check({tag, ":resp_mreq"},  {31'b0, mem_req}, 32'd0);
    // A request presented during RESP must not be taken
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check({tag, ":no_acc_resp"}, {31'b0, mem_req}, 32'd0);
    check({tag, ":ready_back"},  {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) tick();
    check("rst:req_ready",  {31'b0, req_ready}, 32'd1);
    check("rst:resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst:resp_err",   {31'b0, resp_err}, 32'd0);
    check("rst:resp_rdata", resp_rdata, 32'h0);
    check("rst:mem_req",    {31'b0, mem_req}, 32'd0);
    check("rst:mem_we",     {31'b0, mem_we}, 32'd0);
    check("rst:mem_be",     {28'b0, mem_be}, 32'd0);
    check("rst:mem_addr",   mem_addr, 32'h0);
    check("rst:mem_wdata",  mem_wdata, 32'h0);
    rst_n = 1'b1;
    tick();

    do_load("lb",     32'h103, SIZE_BYTE, 1'b1, 32'h80FF_FF11, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu",    32'h103, SIZE_BYTE, 1'b0, 32'h80FF_FF11, 4'b1000, 32'h0000_0080);
    do_load("lbu0",   32'h100, SIZE_BYTE, 1'b0, 32'h80FF_FF11, 4'b0001, 32'h0000_0011);
    do_load("lhu",    32'h202, SIZE_HALF, 1'b0, 32'hBEEF_1234, 4'b1100, 32'h0000_BEEF);
    do_load("lh",     32'h202, SIZE_HALF, 1'b1, 32'hBEEF_1234, 4'b1100, 32'hFFFF_BEEF);
    do_load("lh_lo",  32'h200, SIZE_HALF, 1'b1, 32'hBEEF_1234, 4'b0011, 32'h0000_1234);
    do_load("lw",     32'h800, SIZE_WORD, 1'b0, 32'h1357_9BDF, 4'b1111, 32'h1357_9BDF);
    do_load("lsz3",   32'h700, 2'b11,     1'b1, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF);

    do_store("sb", 32'h301, SIZE_BYTE, 32'h0000_00A5, 4, 4'b0010, 32'hA5A5_A5A5);
    do_store("sh", 32'h302, SIZE_HALF, 32'h1234_ABCD, 0, 4'b1100, 32'hABCD_ABCD);
    do_store("sw", 32'h304, SIZE_WORD, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF);

    // Load timeout: no rvalid for 8 WAIT cycles
    req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_WORD; req_addr = 32'h400;
    tick();
    req_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("tmo:wait_resp", {31'b0, resp_valid}, 32'd0);
      tick();
    end
    check("tmo:resp_valid", {31'b0, resp_valid}, 32'd1);
    check("tmo:resp_err",   {31'b0, resp_err}, 32'd1);
    check("tmo:resp_rdata", resp_rdata, 32'h0);
    tick();
    check("tmo:ready", {31'b0, req_ready}, 32'd1);
    check("tmo:pulse", {31'b0, resp_valid}, 32'd0);

`ifdef DMEM_MISALIGN_TRAP_EN
    req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_WORD; req_addr = 32'h402;
    tick();
    req_valid = 1'b0;
    check("mis:mem_req",    {31'b0, mem_req}, 32'd0);
    check("mis:resp_valid", {31'b0, resp_valid}, 32'd1);
    check("mis:resp_err",   {31'b0, resp_err}, 32'd1);
    check("mis:resp_rdata", resp_rdata, 32'h0);
    tick();
    check("mis:ready", {31'b0, req_ready}, 32'd1);
`else
    do_load("lw_mis", 32'h402, SIZE_WORD, 1'b0, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    do_load("lh_mis", 32'h203, SIZE_HALF, 1'b0, 32'hBEEF_1234, 4'b1100, 32'h0000_BEEF);
`endif

    // Stray rvalid while idle
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    check("stray:resp_valid", {31'b0, resp_valid}, 32'd0);
    check("stray:ready",      {31'b0, req_ready}, 32'd1);

    // Reset while in REQ drops mem_req at once
    req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_WORD; req_addr = 32'h500;
    tick();
    req_valid = 1'b0;
    check("rreq:mem_req_pre", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rreq:mem_req", {31'b0, mem_req}, 32'd0);
    check("rreq:mem_be",  {28'b0, mem_be}, 32'd0);
    check("rreq:ready",   {31'b0, req_ready}, 32'd1);
    rst_n = 1'b1;
    tick();
    check("rreq:no_resp", {31'b0, resp_valid}, 32'd0);

    // Reset while in WAIT; later rvalid produces nothing
    req_valid = 1'b1; req_addr = 32'h600;
    tick();
    req_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rwait:mem_req",    {31'b0, mem_req}, 32'd0);
    check("rwait:resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rwait:ready",      {31'b0, req_ready}, 32'd1);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    check("rwait:late_rv", {31'b0, resp_valid}, 32'd0);
    tick();
    check("rwait:late_rv2", {31'b0, resp_valid}, 32'd0);
    check("rwait:ready2",   {31'b0, req_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of cycles spent in WAIT before an error response.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  core access request.
REQ-005 req_ready  output  1  LSU can accept a request.
REQ-006 req_we  input  1  0 = load, 1 = store (MemRW encoding).
REQ-007 req_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 req_signed  input  1  load result is sign-extended when 1, zero-extended when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  valid with resp_valid; misalignment or timeout.
REQ-014 mem_req  output  1  word-memory request.
REQ-015 mem_we  output  1  word-memory write enable.
REQ-016 mem_be  output  4  byte-lane enables.
REQ-017 mem_addr  output  32  word address, with bits [1:0] = 00.
REQ-018 mem_wdata  output  32  lane-replicated store data.
REQ-019 mem_gnt  input  1  memory accepts mem_req in the current cycle.
REQ-020 mem_rvalid  input  1  read data valid.
REQ-021 mem_rdata  input  32  raw read word.

Function
REQ-022 The FSM SHALL have the states IDLE, REQ, WAIT and RESP; req_ready = 1 only in IDLE.
- IDLE: on req_valid, capture all request fields and go to REQ.
- REQ: assert mem_req, holding all mem_* outputs stable, until mem_gnt.
  - On mem_gnt, a store goes to RESP.
  - On mem_gnt, a load goes to WAIT and clears the timeout counter.
- WAIT: on mem_rvalid, register the formatted data and go to RESP.
  - If the counter reaches TIMEOUT_CYCLES without mem_rvalid, go to RESP with resp_err = 1.
- RESP: resp_valid = 1 for exactly one cycle, then go to IDLE.
REQ-023 Byte-lane enables SHALL be:
- byte: 0001 << addr[1:0]
- half: 0011 << {addr[1],0}
- word: 1111
REQ-024 mem_wdata SHALL replicate the data across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-025 Load data SHALL be extracted from the lane selected by the captured address bits, then sign- or zero-extended to 32 bits per req_signed.
REQ-026 Minimum load latency SHALL be 3 cycles from acceptance to resp_valid (gnt in the first REQ cycle, rvalid in the first WAIT cycle).
REQ-027 Minimum store latency SHALL be 2 cycles from acceptance to resp_valid.
REQ-028 mem_rvalid received outside WAIT SHALL be ignored.
REQ-029 A new request SHALL NOT be accepted in the RESP cycle.

Reset
REQ-030 While rst_n = 0, the state SHALL be IDLE and the outputs SHALL be: req_ready = 1; resp_valid, resp_err, mem_req, mem_we = 0; mem_be = 0000; data and address outputs = 0.
REQ-031 Reset asserted mid-transaction SHALL drop mem_req immediately and discard the transaction with no response.

Configuration
REQ-032 With DMEM_MISALIGN_TRAP_EN defined, a misaligned access (half with addr[0] = 1, or word with addr[1:0] != 00) SHALL be handled as follows:
- skip REQ and WAIT and never assert mem_req;
- enter RESP directly, with resp_err = 1 and resp_rdata = 0.
REQ-033 Without DMEM_MISALIGN_TRAP_EN, misalignment SHALL be ignored:
- half accesses use addr[1] only;
- word accesses force the lane offset to 00;
- resp_err is set only on timeout.

Structure
REQ-034 A shared package SHALL hold:
- the size encodings SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10;
- the FSM state enum;
- the default timeout constant.
REQ-035 One combinational sub-module, lsu_align, SHALL generate mem_be and mem_wdata and perform load extraction and extension; the FSM and counter remain in dmem_lsu.

Verification
REQ-036 LB, addr 0x103, signed, mem_rdata 0x80FF_FF11, gnt immediate, rvalid next cycle -> mem_addr 0x100, mem_be 1000, resp_rdata 0xFFFF_FF80 at cycle 3.
REQ-037 LHU, addr 0x202, mem_rdata 0xBEEF_1234 -> mem_be 1100, resp_rdata 0x0000_BEEF.
REQ-038 SB, addr 0x301, wdata 0x0000_00A5, gnt delayed 4 cycles -> mem_req held 5 cycles, mem_be 0010, mem_wdata 0xA5A5_A5A5, resp_valid 1 cycle after gnt, resp_err 0.
REQ-039 LW, addr 0x400, rvalid never asserted, TIMEOUT_CYCLES = 8 -> resp_valid with resp_err = 1 and resp_rdata = 0 after 8 WAIT cycles, then req_ready = 1.
REQ-040 LW, addr 0x402:
- with DMEM_MISALIGN_TRAP_EN -> no mem_req, resp_err = 1 one cycle after acceptance;
- without it -> mem_addr 0x400, mem_be 1111.
REQ-041 rst_n pulsed low while in WAIT -> mem_req and resp_valid are 0 immediately; a later rvalid produces no response.
